// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, register map constants and FSM states for the APB completer
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;
    localparam logic [APB_DATA_W-1:0] APB_SLV_ID = 32'hA9B0_0001;
    localparam int REG_ID = 0;
    localparam int REG_CNT = 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} apb_slv_state_e;
endpackage

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB register bank with read-only ID/transfer counter and programmable wait states
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NR = 7'(NUM_REGS);

    apb_slv_state_e state, next;
    logic [3:0] wcnt;
    logic wr_q, err_q;
    logic [APB_ADDR_W-1:0] addr_q, addr_s;
    logic [APB_DATA_W-1:0] wdata_q, xfer_cnt, rd_s;
    logic [APB_DATA_W-1:0] mem [NUM_REGS];
    logic setup, wr_s, err_s, commit;
    logic [5:0] idx_s;

    // In IDLE the live bus is decoded so a zero-wait transfer can answer on the next edge; afterwards the latched copy is used
    always_comb begin
        setup = (state == S_IDLE) && psel && !penable;
        addr_s = (state == S_IDLE) ? paddr : addr_q;
        wr_s = (state == S_IDLE) ? pwrite : wr_q;
        idx_s = addr_s[7:2];
        err_s = (addr_s[1:0] != 2'b00) || ({1'b0, idx_s} >= NR) || (wr_s && idx_s <= 6'(REG_CNT));
        rd_s = (idx_s == 6'(REG_ID)) ? APB_SLV_ID :
               (idx_s == 6'(REG_CNT)) ? xfer_cnt : mem[idx_s[IW-1:0]];
        commit = (state == S_DONE) && psel && penable && !err_q;
    end

    // Next-state: a dropped select aborts, DONE always lasts exactly one cycle
    always_comb begin
        next = S_IDLE;
        if (state == S_IDLE)
            next = setup ? ((WAIT_STATES == 0) ? S_DONE : S_WAIT) : S_IDLE;
        else if (state == S_WAIT)
            next = !psel ? S_IDLE : (wcnt == 4'd1) ? S_DONE : S_WAIT;
    end

    // State, request latch, wait counter, registered response and register bank updates
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= S_IDLE;
            wcnt <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            xfer_cnt <= '0;
            pready <= 1'b0;
            pslverr <= 1'b0;
            prdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            state <= next;
            if (setup) begin
                wr_q <= pwrite;
                addr_q <= paddr;
                wdata_q <= pwdata;
                err_q <= err_s;
                wcnt <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            pready <= (next == S_DONE);
            pslverr <= (next == S_DONE) && err_s;
            prdata <= ((next == S_DONE) && !err_s && !wr_s) ? rd_s : '0;
            if (commit) begin
                if (wr_q) mem[addr_q[IW+1:2]] <= wdata_q;
                xfer_cnt <= xfer_cnt + 32'd1;
            end
        end
    end
endmodule
